fib_sequencer: RTL

Controller that sequences the 16-bit Fibonacci generator: it paces requests with an internal 10 Hz-class tick, pulses the generator's enable, and captures each returned term. It forwards each term with its index to the display path over a valid/ready handshake, and stops after a programmed number of terms. It sits between the board-level start/stop controls and the generator, and owns the generator's reset.

---
 rtl/fib_seq_pkg.sv | 18 +
 rtl/edge_detector.sv | 19 +
 rtl/fib_sequencer_tick.sv | 26 ++
 rtl/fib_sequencer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fib_seq_pkg.sv
// Shared types and widths for the Fibonacci sequencer.
package fib_seq_pkg;

    localparam int IDX_W  = 5;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT_TICK,
        S_REQ,
        S_WAIT_VALID,
        S_PUSH,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector for a level input already in the clk domain.
module edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_prev;

    assign rise = sig & ~sig_prev;

    // One cycle of history; cleared by the active-low synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) sig_prev <= 1'b0;
        else      sig_prev <= sig;
    end

endmodule

// File: rtl/fib_sequencer_tick.sv
// Request prescaler: counts 0..TICK_DIV-1 while enabled, wraps, and emits a
// one-cycle tick on the last count. Holds its value while disabled.
module seq_tick_gen #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(TICK_DIV - 1));

    // Prescaler counter: clear wins, otherwise advance only when enabled.
    always_ff @(posedge clk) begin
        if (!rst)      cnt <= '0;
        else if (clr)  cnt <= '0;
        else if (en)   cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/fib_sequencer.sv
// Sequencer for the 16-bit Fibonacci generator: paced requests, term capture,
// valid/ready forwarding with index, run length MAX_TERMS.
// Optional build macro FIB_SEQ_CHECK_EN: verifies each captured term (idx>=2)
// against the sum of the previous two accepted terms and errors on mismatch.
module fib_sequencer
    import fib_seq_pkg::*;
#(
    parameter int TICK_DIV  = 10_000_000,
    parameter int MAX_TERMS = 24,
    parameter int TIMEOUT   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              gen_rst,
    output logic              gen_en,
    input  logic              gen_valid,
    input  logic [DATA_W-1:0] gen_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t            state, nxt;
    logic              start_rise;
    logic              tick;
    logic              rst_hold;
    logic              term_bad;
    logic [IDX_W-1:0]  idx;
    logic [TW-1:0]     wcnt;

    edge_detector u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (start),
        .rise (start_rise)
    );

    seq_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == S_CLEAR),
        .en   (state == S_WAIT_TICK),
        .tick (tick)
    );

    assign out_idx = idx;

`ifdef FIB_SEQ_CHECK_EN
    logic [DATA_W-1:0] prev1, prev2;
    logic [DATA_W:0]   sum;

    assign sum      = {1'b0, prev1} + {1'b0, prev2};
    assign term_bad = (idx >= IDX_W'(2)) && ({1'b0, gen_data} != sum);

    // Shadow copies of the last two terms the consumer accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev1 <= '0;
            prev2 <= '0;
        end else if (state == S_PUSH && out_ready) begin
            prev2 <= prev1;
            prev1 <= out_data;
        end
    end
`else
    assign term_bad = 1'b0;
`endif

    // State register; reset forces IDLE.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    // gen_rst stays high in the cycle right after reset until the first normal edge.
    always_ff @(posedge clk) begin
        if (!rst) rst_hold <= 1'b1;
        else      rst_hold <= 1'b0;
    end

    // Term index, captured term and response-timeout counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx      <= '0;
            out_data <= '0;
            wcnt     <= '0;
        end else begin
            unique case (state)
                S_CLEAR:      idx <= '0;
                S_REQ:        wcnt <= '0;
                S_WAIT_VALID: begin
                    wcnt <= wcnt + 1'b1;
                    if (gen_valid) out_data <= gen_data;
                end
                S_PUSH:       if (out_ready && idx != IDX_W'(MAX_TERMS - 1)) idx <= idx + 1'b1;
                default:      ;
            endcase
        end
    end

    // Next-state and Moore outputs; stop beats a start edge, which beats everything else.
    always_comb begin
        nxt       = state;
        gen_rst   = rst_hold;
        gen_en    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        unique case (state)
            S_CLEAR:      begin gen_rst = 1'b1; busy = 1'b1; end
            S_WAIT_TICK:  busy = 1'b1;
            S_REQ:        begin gen_en = 1'b1; busy = 1'b1; end
            S_WAIT_VALID: busy = 1'b1;
            S_PUSH:       begin out_valid = 1'b1; busy = 1'b1; end
            S_DONE:       done = 1'b1;
            S_ERR:        err = 1'b1;
            default:      ;
        endcase

        if (stop) begin
            nxt = S_IDLE;
        end else if (start_rise) begin
            nxt = S_CLEAR;
        end else begin
            unique case (state)
                S_CLEAR:      nxt = S_WAIT_TICK;
                S_WAIT_TICK:  if (tick) nxt = S_REQ;
                S_REQ:        nxt = S_WAIT_VALID;
                S_WAIT_VALID: begin
                    if (gen_valid)                        nxt = term_bad ? S_ERR : S_PUSH;
                    else if (wcnt == TW'(TIMEOUT - 1))    nxt = S_ERR;
                end
                S_PUSH:       if (out_ready) nxt = (idx == IDX_W'(MAX_TERMS - 1)) ? S_DONE : S_WAIT_TICK;
                default:      ;
            endcase
        end
    end

endmodule
